// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle datapath control FSM.
// Opcode constants, datapath select encodings, FSM states and the packed control word.
package mc_ctrl_pkg;

   localparam int OP_W = 6;
   typedef logic [OP_W-1:0] opcode_t;

   localparam opcode_t OP_RTYPE = 6'b000000;
   localparam opcode_t OP_LW    = 6'b100011;
   localparam opcode_t OP_SW    = 6'b101011;
   localparam opcode_t OP_BEQ   = 6'b000100;
   localparam opcode_t OP_J     = 6'b000010;
   localparam opcode_t OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUB_REG     = 2'b00;
   localparam logic [1:0] ALUB_FOUR    = 2'b01;
   localparam logic [1:0] ALUB_IMM     = 2'b10;
   localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_e;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       instr_done;
      logic       illegal_op;
   } ctrl_t;

   function automatic logic is_legal_op(input opcode_t op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
   endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
interface mc_ctrl_if #(
   parameter int OP_WIDTH = 6
);
   logic [OP_WIDTH-1:0] Op;
   logic                Zero;
   logic                mem_ready;
   logic                PCWrite;
   logic                PCWriteCond;
   logic                IorD;
   logic                MemRead;
   logic                MemWrite;
   logic                IRWrite;
   logic                MemtoReg;
   logic                RegDst;
   logic                RegWrite;
   logic                ALUSrcA;
   logic [1:0]          ALUSrcB;
   logic [1:0]          ALUOp;
   logic [1:0]          PCSource;
   logic                instr_done;
   logic                illegal_op;

   modport master (
      input  Op, Zero, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op
   );

   modport slave (
      output Op, Zero, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op
   );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational output decode: state plus the few Mealy inputs map to the control word.
// en_i low forces every control to 0 (held in reset).
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  state_e  state_i,
   input  opcode_t op_i,
   input  logic    mem_ready_i,
   input  logic    en_i,
   output ctrl_t   ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      if (en_i) begin
         case (state_i)
            S_FETCH: begin
               ctrl_o.mem_read  = 1'b1;
               ctrl_o.alu_src_b = ALUB_FOUR;
               ctrl_o.ir_write  = mem_ready_i;
               ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
               ctrl_o.alu_src_b  = ALUB_IMM_SH2;
               ctrl_o.illegal_op = !is_legal_op(op_i);
            end
            S_MEMADR, S_ADDIEX: begin
               ctrl_o.alu_src_a = 1'b1;
               ctrl_o.alu_src_b = ALUB_IMM;
            end
            S_MEMRD: begin
               ctrl_o.mem_read = 1'b1;
               ctrl_o.iord     = 1'b1;
            end
            S_MEMWB: begin
               ctrl_o.reg_write  = 1'b1;
               ctrl_o.mem_to_reg = 1'b1;
               ctrl_o.instr_done = 1'b1;
            end
            S_MEMWR: begin
               ctrl_o.mem_write  = 1'b1;
               ctrl_o.iord       = 1'b1;
               ctrl_o.instr_done = mem_ready_i;
            end
            S_EXEC: begin
               ctrl_o.alu_src_a = 1'b1;
               ctrl_o.alu_src_b = ALUB_REG;
               ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
               ctrl_o.reg_write  = 1'b1;
               ctrl_o.reg_dst    = 1'b1;
               ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
               ctrl_o.alu_src_a     = 1'b1;
               ctrl_o.alu_op        = ALUOP_SUB;
               ctrl_o.pc_write_cond = 1'b1;
               ctrl_o.pc_source     = PCSRC_ALUOUT;
               ctrl_o.instr_done    = 1'b1;
            end
            S_JUMP: begin
               ctrl_o.pc_write   = 1'b1;
               ctrl_o.pc_source  = PCSRC_JUMP;
               ctrl_o.instr_done = 1'b1;
            end
            S_ADDIWB: begin
               ctrl_o.reg_write  = 1'b1;
               ctrl_o.instr_done = 1'b1;
            end
            default: ctrl_o = '0;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Main multicycle control FSM: state register and next-state logic; outputs come from mc_ctrl_decode.
module multicycle_control
   import mc_ctrl_pkg::*;
#(
   parameter int OP_WIDTH = 6
) (
   input logic       clk,
   input logic       rst_n,
   mc_ctrl_if.master bus
);

   state_e              state_q, state_d;
   logic [OP_WIDTH-1:0] op_raw;
   opcode_t             op;
   ctrl_t               ctrl;

   assign op_raw = bus.Op;
   assign op     = opcode_t'(op_raw);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if ((op == OP_LW) || (op == OP_SW)) state_d = S_MEMADR;
            else if (op == OP_RTYPE)            state_d = S_EXEC;
            else if (op == OP_BEQ)              state_d = S_BRANCH;
            else if (op == OP_J)                state_d = S_JUMP;
            else if (op == OP_ADDI)             state_d = S_ADDIEX;
            else                                state_d = S_FETCH;
         end
         S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   state_d = S_ALUWB;
         S_ADDIEX: state_d = S_ADDIWB;
         default:  state_d = S_FETCH;
      endcase
   end

   // Gating with rst_n keeps every strobe, including FETCH's MemRead, low during reset.
   mc_ctrl_decode u_decode (
      .state_i     (state_q),
      .op_i        (op),
      .mem_ready_i (bus.mem_ready),
      .en_i        (rst_n),
      .ctrl_o      (ctrl)
   );

   assign bus.PCWrite     = ctrl.pc_write;
   assign bus.PCWriteCond = ctrl.pc_write_cond;
   assign bus.IorD        = ctrl.iord;
   assign bus.MemRead     = ctrl.mem_read;
   assign bus.MemWrite    = ctrl.mem_write;
   assign bus.IRWrite     = ctrl.ir_write;
   assign bus.MemtoReg    = ctrl.mem_to_reg;
   assign bus.RegDst      = ctrl.reg_dst;
   assign bus.RegWrite    = ctrl.reg_write;
   assign bus.ALUSrcA     = ctrl.alu_src_a;
   assign bus.ALUSrcB     = ctrl.alu_src_b;
   assign bus.ALUOp       = ctrl.alu_op;
   assign bus.PCSource    = ctrl.pc_source;
   assign bus.instr_done  = ctrl.instr_done;
   assign bus.illegal_op  = ctrl.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control-word checks against hand-written vectors.
module tb_multicycle_control;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   mc_ctrl_if #(.OP_WIDTH(6)) bus ();

   multicycle_control #(.OP_WIDTH(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,instr_done,illegal_op}
   logic [17:0] obs;
   assign obs = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                 bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                 bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.instr_done, bus.illegal_op};

   localparam logic [17:0] V_ZERO    = 18'b0;
   localparam logic [17:0] V_FETCH_W = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
   localparam logic [17:0] V_FETCH_R = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
   localparam logic [17:0] V_DECODE  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
   localparam logic [17:0] V_DEC_ILL = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_1;
   localparam logic [17:0] V_MEMADR  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
   localparam logic [17:0] V_MEMRD   = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
   localparam logic [17:0] V_MEMWB   = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
   localparam logic [17:0] V_MEMWR_W = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
   localparam logic [17:0] V_MEMWR_R = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
   localparam logic [17:0] V_EXEC    = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
   localparam logic [17:0] V_ALUWB   = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
   localparam logic [17:0] V_BRANCH  = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
   localparam logic [17:0] V_JUMP    = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
   localparam logic [17:0] V_ADDIEX  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
   localparam logic [17:0] V_ADDIWB  = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000, BADOP = 6'b111111;

   task automatic chk(input string tag, input logic [17:0] exp);
      #1;
      total++;
      $display("step %-12s obs=%b exp=%b", tag, obs, exp);
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic step(input string tag, input logic rdy, input logic [5:0] op,
                       input logic [17:0] exp);
      bus.mem_ready = rdy;
      bus.Op        = op;
      chk(tag, exp);
      tick();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.Op = LW;
      bus.Zero = 1'b0;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      chk("reset", V_ZERO);
      tick();
      rst_n = 1'b1;

      // LW, zero-wait
      step("lw_fetch",  1'b1, LW, V_FETCH_R);
      step("lw_decode", 1'b1, LW, V_DECODE);
      step("lw_memadr", 1'b1, LW, V_MEMADR);
      step("lw_memrd",  1'b1, LW, V_MEMRD);
      step("lw_memwb",  1'b1, LW, V_MEMWB);

      // R-type
      step("rt_fetch",  1'b1, RT, V_FETCH_R);
      step("rt_decode", 1'b0, RT, V_DECODE);
      step("rt_exec",   1'b0, RT, V_EXEC);
      step("rt_aluwb",  1'b0, RT, V_ALUWB);

      // SW with 3 wait cycles in MEMWR, preceded by one fetch wait
      step("sw_fetchw", 1'b0, SW, V_FETCH_W);
      step("sw_fetch",  1'b1, SW, V_FETCH_R);
      step("sw_decode", 1'b1, SW, V_DECODE);
      step("sw_memadr", 1'b1, SW, V_MEMADR);
      step("sw_wr_w1",  1'b0, SW, V_MEMWR_W);
      step("sw_wr_w2",  1'b0, SW, V_MEMWR_W);
      step("sw_wr_w3",  1'b0, SW, V_MEMWR_W);
      step("sw_wr_rdy", 1'b1, SW, V_MEMWR_R);

      // BEQ with Zero=1 then Zero=0; controller output must not depend on Zero
      bus.Zero = 1'b1;
      step("beq1_fetch",  1'b1, BEQ, V_FETCH_R);
      step("beq1_decode", 1'b1, BEQ, V_DECODE);
      step("beq1_branch", 1'b1, BEQ, V_BRANCH);
      bus.Zero = 1'b0;
      step("beq0_fetch",  1'b1, BEQ, V_FETCH_R);
      step("beq0_decode", 1'b1, BEQ, V_DECODE);
      step("beq0_branch", 1'b1, BEQ, V_BRANCH);

      // Illegal opcode returns straight to FETCH
      step("ill_fetch",  1'b1, BADOP, V_FETCH_R);
      step("ill_decode", 1'b1, BADOP, V_DEC_ILL);

      // Jump
      step("j_fetch",  1'b1, JMP, V_FETCH_R);
      step("j_decode", 1'b1, JMP, V_DECODE);
      step("j_jump",   1'b1, JMP, V_JUMP);

      // ADDI
      step("addi_fetch",  1'b1, ADDI, V_FETCH_R);
      step("addi_decode", 1'b1, ADDI, V_DECODE);
      step("addi_ex",     1'b0, ADDI, V_ADDIEX);
      step("addi_wb",     1'b0, ADDI, V_ADDIWB);

      // LW with one MEMRD wait, then reset pulsed in MEMWB
      step("lw2_fetch",  1'b1, LW, V_FETCH_R);
      step("lw2_decode", 1'b1, LW, V_DECODE);
      step("lw2_memadr", 1'b0, LW, V_MEMADR);
      step("lw2_memrd_w", 1'b0, LW, V_MEMRD);
      step("lw2_memrd_r", 1'b1, LW, V_MEMRD);
      bus.mem_ready = 1'b1;
      chk("lw2_memwb", V_MEMWB);
      rst_n = 1'b0;
      chk("rst_async", V_ZERO);
      tick();
      chk("rst_hold", V_ZERO);
      rst_n = 1'b1;
      step("post_fetch",  1'b1, RT, V_FETCH_R);
      step("post_decode", 1'b1, RT, V_DECODE);
      step("post_exec",   1'b1, RT, V_EXEC);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle datapath. It sequences instruction fetch, decode, execute, memory access and write-back, one instruction at a time, over a shared memory port that may stall. It drives every datapath select and write-enable, including MemtoReg, which steers the register-file write-data mux between ALUOut and MDROut, and RegWrite.

## Interface
Parameters:
- OP_WIDTH, 6, opcode field width (instr[31:26]).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- Op  input  OP_WIDTH  opcode from the instruction register.
- Zero  input  1  ALU zero flag.
- mem_ready  input  1  memory has completed the current read or write this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load qualified by Zero.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  instruction register load.
- MemtoReg  output  1  write-data select: 0 = ALUOut, 1 = MDROut.
- RegDst  output  1  destination select: 0 = rt, 1 = rd.
- RegWrite  output  1  register-file write.
- ALUSrcA  output  1  ALU A input: 0 = PC, 1 = register A.
- ALUSrcB  output  2  ALU B input: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- ALUOp  output  2  00 = add, 01 = subtract, 10 = use funct field.
- PCSource  output  2  next-PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- instr_done  output  1  one-cycle pulse on the last cycle of each instruction.
- illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode.

## Operation
- Opcodes: R-type 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, ADDIEX, ADDIWB.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite equal mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Next state by Op: LW or SW -> MEMADR; R-type -> EXEC; BEQ -> BRANCH; J -> JUMP; ADDI -> ADDIEX.
  - Any other Op: illegal_op=1, next state FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state MEMRD for LW, MEMWR for SW.
- MEMRD: MemRead=1, IorD=1. Stay while mem_ready=0; go to MEMWB when mem_ready=1 (MDR is loaded every cycle by the datapath).
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Next state FETCH.
- MEMWR: MemWrite=1, IorD=1. Stay while mem_ready=0. When mem_ready=1: instr_done=1, next state FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- ALUWB: RegWrite=1, MemtoReg=0, RegDst=1, instr_done=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Next state FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state ADDIWB.
- ADDIWB: RegWrite=1, MemtoReg=0, RegDst=0, instr_done=1. Next state FETCH.
- Any output not listed for a state is 0.
- An unreachable state encoding decodes all outputs to 0 and recovers to FETCH on the next edge.

## Timing
- State register updates on the clk rising edge. The async clear sets the state to FETCH.
- Outputs are combinational from state. The only Mealy terms are mem_ready (FETCH, MEMWR) and Op (DECODE illegal_op).
- While rst_n=0, every output is 0, including FETCH's MemRead. Outputs first become active in the cycle after rst_n deasserts.
- rst_n assertion mid-instruction aborts the instruction immediately. No RegWrite or MemWrite may be asserted while rst_n=0.
- Latency with zero-wait memory (mem_ready=1 on first request): LW 5 cycles; SW, R-type, ADDI 4; BEQ, J 3; illegal 2.
- Each memory wait cycle adds 1 cycle. Requests hold MemRead/MemWrite and IorD stable until mem_ready=1.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum (4-bit);
  - opcode constants;
  - ALUOp, ALUSrcB and PCSource encodings.
- Sub-module mc_ctrl_decode: purely combinational mapping of state, Op and mem_ready to outputs. The top level holds the state register and next-state logic.

## Test plan
- Reset, then LW with zero-wait memory: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; MemtoReg=1 and RegWrite=1 only in cycle 5; instr_done pulses in cycle 5.
- R-type Op=000000: RegDst=1, MemtoReg=0, RegWrite=1 in cycle 4; ALUOp=10 in cycle 3.
- SW with mem_ready low for 3 cycles in MEMWR: MemWrite=1 and IorD=1 held for 4 cycles; instr_done in the 4th; next state FETCH.
- BEQ with Zero=1, then BEQ with Zero=0: PCWriteCond=1 and PCSource=01 in cycle 3 both times; PCWrite=0 throughout.
- Op=111111: illegal_op pulses in DECODE and the FSM returns to FETCH; Op=000010 (J): PCWrite=1 and PCSource=10 in cycle 3.
- rst_n pulsed low during MEMWB of an LW: RegWrite drops to 0 asynchronously; after release the FSM restarts in FETCH with MemRead=1.
